// File: rtl/bus_pkg.sv
// Shared definitions for the NES CPU-side bus: memory-map boundaries,
// 6502 read/write encoding and the OAM DMA state type.
package bus_pkg;

  localparam logic [15:0] RAM_END   = 16'h1FFF;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PPU_END   = 16'h3FFF;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] IO_END    = 16'h4017;
  localparam logic [15:0] CART_BASE = 16'h4020;
  localparam logic [15:0] DMA_REG   = 16'h4014;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// $4014 OAM DMA engine: stalls the CPU, reads one 256-byte page over the
// bus and streams it into PPU OAM one byte every other cycle.
module oam_dma #(
  parameter int DMA_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        parity,
  input  logic        trig,
  input  logic [7:0]  trig_page,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        grant,
  output logic [15:0] dma_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata
);
  import bus_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_r, state_s;
  logic [7:0] page_r, idx_r, byte_r;
  logic       odd_start_r;

  // Next-state logic; alignment follows the parity of the cycle that wrote DMA_REG.
  always_comb begin
    state_s = state_r;
    case (state_r)
      DMA_IDLE: begin
        if (trig) state_s = DMA_HALT;
        else      state_s = DMA_IDLE;
      end
      DMA_HALT: begin
        if (odd_start_r) state_s = DMA_ALIGN;
        else             state_s = DMA_READ;
      end
      DMA_ALIGN: state_s = DMA_READ;
      DMA_READ:  state_s = DMA_WRITE;
      DMA_WRITE: begin
        if (idx_r == LAST_IDX) state_s = DMA_IDLE;
        else                   state_s = DMA_READ;
      end
      default:   state_s = DMA_IDLE;
    endcase
  end

  // State, page/index/byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= DMA_IDLE;
      page_r      <= 8'h00;
      idx_r       <= 8'h00;
      byte_r      <= 8'h00;
      odd_start_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == DMA_IDLE && trig) begin
        page_r      <= trig_page;
        idx_r       <= 8'h00;
        odd_start_r <= parity;
      end
      if (state_r == DMA_READ)  byte_r <= rd_data;
      if (state_r == DMA_WRITE) idx_r  <= idx_r + 8'd1;
    end
  end

  assign busy      = (state_r != DMA_IDLE);
  assign grant     = (state_r == DMA_READ);
  assign dma_addr  = {page_r, idx_r};
  assign oam_we    = (state_r == DMA_WRITE);
  assign oam_wdata = byte_r;

endmodule

// File: rtl/cpu_bus.sv
// NES CPU system bus: address decode, 2 KiB work RAM, read mux with
// open-bus latch, and bus arbitration with the OAM DMA engine.
module cpu_bus #(
  parameter int          RAM_AW  = 11,
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter int          DMA_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        ppu_cs,
  output logic [2:0]  ppu_reg,
  output logic        ppu_rw,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  output logic        io_cs,
  output logic [4:0]  io_addr,
  input  logic [7:0]  io_rdata,
  output logic        cart_cs,
  output logic [15:0] cart_addr,
  input  logic [7:0]  cart_rdata
);
  import bus_pkg::*;

  logic        parity_r;
  logic [7:0]  latch_r;
  logic [7:0]  ram_r [0:(1<<RAM_AW)-1];
  logic        dma_busy_s, dma_grant_s, trig_s;
  logic [15:0] dma_addr_s, act_addr_s;
  logic        act_valid_s, act_rw_s;
  logic        ram_sel_s, ppu_sel_s, io_sel_s, cart_sel_s;
  logic [7:0]  rdata_s;

  // Bus master: CPU while DMA is idle, DMA during READ, nobody otherwise.
  always_comb begin
    act_valid_s = 1'b0;
    act_rw_s    = RW_READ;
    act_addr_s  = cpu_addr;
    if (dma_grant_s) begin
      act_valid_s = 1'b1;
      act_rw_s    = RW_READ;
      act_addr_s  = dma_addr_s;
    end else if (!dma_busy_s) begin
      act_valid_s = 1'b1;
      act_rw_s    = cpu_rw;
      act_addr_s  = cpu_addr;
    end else begin
      act_valid_s = 1'b0;
      act_rw_s    = RW_READ;
      act_addr_s  = cpu_addr;
    end
  end

  // Single-hot decode; $4018-$401F and DMA_REG select nothing.
  always_comb begin
    ram_sel_s  = 1'b0;
    ppu_sel_s  = 1'b0;
    io_sel_s   = 1'b0;
    cart_sel_s = 1'b0;
    if (!act_valid_s) begin
      ram_sel_s = 1'b0;
    end else if (act_addr_s <= RAM_END) begin
      ram_sel_s = 1'b1;
    end else if (act_addr_s >= PPU_BASE && act_addr_s <= PPU_END) begin
      ppu_sel_s = 1'b1;
    end else if (act_addr_s >= IO_BASE && act_addr_s <= IO_END && act_addr_s != DMA_REG) begin
      io_sel_s = 1'b1;
    end else if (act_addr_s >= CART_BASE) begin
      cart_sel_s = 1'b1;
    end else begin
      ram_sel_s = 1'b0;
    end
  end

  // Read mux; unselected reads see the open-bus latch.
  always_comb begin
    rdata_s = latch_r;
    if (ram_sel_s)       rdata_s = ram_r[act_addr_s[RAM_AW-1:0]];
    else if (ppu_sel_s)  rdata_s = ppu_rdata;
    else if (io_sel_s)   rdata_s = io_rdata;
    else if (cart_sel_s) rdata_s = cart_rdata;
    else                 rdata_s = latch_r;
  end

  // Work RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_sel_s && act_rw_s == RW_WRITE) ram_r[act_addr_s[RAM_AW-1:0]] <= cpu_wdata;
  end

  // Cycle parity and open-bus latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
      latch_r  <= 8'h00;
    end else begin
      parity_r <= ~parity_r;
      if (act_valid_s) latch_r <= (act_rw_s == RW_READ) ? rdata_s : cpu_wdata;
    end
  end

  assign trig_s = !dma_busy_s && (cpu_rw == RW_WRITE) && (cpu_addr == DMA_REG);

  oam_dma #(.DMA_LEN(DMA_LEN)) u_dma (
    .clk       (clk),
    .reset     (reset),
    .parity    (parity_r),
    .trig      (trig_s),
    .trig_page (cpu_wdata),
    .rd_data   (rdata_s),
    .busy      (dma_busy_s),
    .grant     (dma_grant_s),
    .dma_addr  (dma_addr_s),
    .oam_we    (oam_we),
    .oam_wdata (oam_wdata)
  );

  assign cpu_rdata = rdata_s;
  assign cpu_rdy   = !dma_busy_s;
  assign ppu_cs    = ppu_sel_s;
  assign ppu_reg   = act_addr_s[2:0];
  assign ppu_rw    = act_rw_s;
  assign ppu_wdata = cpu_wdata;
  assign io_cs     = io_sel_s;
  assign io_addr   = act_addr_s[4:0];
  assign cart_cs   = cart_sel_s;
  assign cart_addr = act_addr_s;

endmodule

// File: tb/tb_cpu_bus.sv
// Self-checking bench for cpu_bus: a cycle-level reference model of the
// memory map and DMA timing, plus directed tests with literal expectations.
module tb_cpu_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = 16'h4018;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        ppu_cs, ppu_rw, io_cs, cart_cs, oam_we;
  logic [2:0]  ppu_reg;
  logic [7:0]  ppu_wdata, oam_wdata;
  logic [4:0]  io_addr;
  logic [15:0] cart_addr;
  logic [7:0]  ppu_rdata  = 8'h5A;
  logic [7:0]  io_rdata   = 8'h6B;
  logic [7:0]  cart_rdata = 8'h7C;

  cpu_bus dut (
    .clk(clk), .reset(reset), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .ppu_cs(ppu_cs), .ppu_reg(ppu_reg), .ppu_rw(ppu_rw), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata), .oam_we(oam_we), .oam_wdata(oam_wdata),
    .io_cs(io_cs), .io_addr(io_addr), .io_rdata(io_rdata),
    .cart_cs(cart_cs), .cart_addr(cart_addr), .cart_rdata(cart_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_par = 1'b0;
  int         m_k = 0;
  int         m_len = 513;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_latch = 8'h00;
  logic [7:0] m_ram [0:2047];
  bit         m_known [0:2047];

  // 0 ram, 1 ppu, 2 io, 3 open bus, 4 cartridge
  function automatic int region(input logic [15:0] a);
    if (a <= 16'h1FFF) return 0;
    if (a <= 16'h3FFF) return 1;
    if (a <= 16'h4017) return (a == 16'h4014) ? 3 : 2;
    if (a <  16'h4020) return 3;
    return 4;
  endfunction

  always @(negedge clk) begin
    int          r, reg_i;
    logic [15:0] aa, wa;
    logic        av, arw;
    logic [7:0]  exp_rd;
    bit          known;
    logic [2:0]  exp_cs;
    r = -100;
    if (m_k > 0) r = m_k - (m_len - 511);
    if (m_k == 0) begin
      av = 1'b1; arw = cpu_rw; aa = cpu_addr;
    end else if (r >= 0 && r % 2 == 0) begin
      av = 1'b1; arw = 1'b1; aa = {m_page, 8'(r / 2)};
    end else begin
      av = 1'b0; arw = 1'b1; aa = cpu_addr;
    end
    reg_i  = region(aa);
    exp_cs = av ? {reg_i == 1, reg_i == 2, reg_i == 4} : 3'b000;
    known  = 1'b1;
    case (reg_i)
      0: begin exp_rd = m_ram[aa[10:0]]; known = m_known[aa[10:0]]; end
      1: exp_rd = 8'h5A;
      2: exp_rd = 8'h6B;
      4: exp_rd = 8'h7C;
      default: exp_rd = m_latch;
    endcase
    if (chk_en) begin
      chk("m_rdy", cpu_rdy, m_k == 0);
      chk("m_oam_we", oam_we, r >= 1 && r % 2 == 1);
      if (r >= 1 && r % 2 == 1) begin
        wa = {m_page, 8'((r - 1) / 2)};
        chk("m_oam_wdata", oam_wdata, m_ram[wa[10:0]]);
      end
      chk("m_cs", {ppu_cs, io_cs, cart_cs}, exp_cs);
      if (exp_cs[2]) chk("m_ppu_side", {ppu_reg, ppu_rw, ppu_wdata}, {aa[2:0], arw, cpu_wdata});
      if (exp_cs[1]) chk("m_io_addr", io_addr, aa[4:0]);
      if (exp_cs[0]) chk("m_cart_addr", cart_addr, aa);
      if (av && arw && known) chk("m_rdata", cpu_rdata, exp_rd);
    end
    if (reset) begin
      m_par = 1'b0; m_k = 0; m_latch = 8'h00;
    end else begin
      if (av) m_latch = arw ? exp_rd : cpu_wdata;
      if (m_k == 0 && !cpu_rw && reg_i == 0) begin
        m_ram[cpu_addr[10:0]]   = cpu_wdata;
        m_known[cpu_addr[10:0]] = 1'b1;
      end
      if (m_k == 0 && !cpu_rw && cpu_addr == 16'h4014) begin
        m_k = 1; m_len = m_par ? 514 : 513; m_page = cpu_wdata;
      end else if (m_k != 0) begin
        m_k = (m_k == m_len) ? 0 : m_k + 1;
      end
      m_par = ~m_par;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_rw = 1'b1; cpu_addr = 16'h4018; cpu_wdata = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
    cpu_rw = 1'b1; cpu_addr = a;
    @(negedge clk);
    chk(nm, cpu_rdata, exp);
    chk({nm, "_cs"}, {ppu_cs, io_cs, cart_cs}, 3'b000);
    tick();
    idle();
  endtask

  task automatic run_dma(input string nm, input bit want_odd, input int exp_stall,
                         input logic [15:0] hostile_addr);
    int  stall, pulses, guard;
    bit  done;
    stall = 0; pulses = 0; guard = 0; done = 1'b0;
    if (m_par != want_odd) tick();
    wr(16'h4014, 8'h02);
    cpu_rw = 1'b0; cpu_addr = hostile_addr; cpu_wdata = 8'hFF;
    while (!done && guard < 2000) begin
      @(negedge clk);
      if (!cpu_rdy) stall++;
      if (oam_we) begin
        chk({nm, "_data"}, oam_wdata, pulses);
        pulses++;
      end
      done = cpu_rdy;
      tick();
      guard++;
      if (m_k == 0) idle();
    end
    idle();
    chk({nm, "_timeout"}, guard >= 2000, 1'b0);
    chk({nm, "_stall"}, stall, exp_stall);
    chk({nm, "_pulses"}, pulses, 256);
  endtask

  initial begin
    int pulses, guard;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rdy", cpu_rdy, 1'b1);
    chk("reset_oam_we", oam_we, 1'b0);
    chk("reset_oam_wdata", oam_wdata, 8'h00);
    tick();

    // RAM mirroring
    wr(16'h0005, 8'hA5);
    rd("mirror_0805", 16'h0805, 8'hA5);
    rd("mirror_1005", 16'h1005, 8'hA5);
    rd("mirror_1805", 16'h1805, 8'hA5);

    // PPU write, then open bus returns last data
    cpu_rw = 1'b0; cpu_addr = 16'h3FFF; cpu_wdata = 8'h3C;
    @(negedge clk);
    chk("ppu_cs", ppu_cs, 1'b1);
    chk("ppu_reg", ppu_reg, 3'd7);
    chk("ppu_wdata", ppu_wdata, 8'h3C);
    chk("ppu_rw", ppu_rw, 1'b0);
    tick();
    rd("openbus_401a", 16'h401A, 8'h3C);

    // io and cartridge read data
    cpu_rw = 1'b1; cpu_addr = 16'h4016;
    @(negedge clk);
    chk("io_read", {io_cs, io_addr, cpu_rdata}, {1'b1, 5'h16, 8'h6B});
    tick();
    cpu_addr = 16'h8000;
    @(negedge clk);
    chk("cart_read", {cart_cs, cpu_rdata}, {1'b1, 8'h7C});
    tick();
    rd("openbus_after_cart", 16'h4014, 8'h7C);

    // preload page 2 and a sentinel
    for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i));
    wr(16'h0010, 8'h11);

    run_dma("dma_even", 1'b0, 513, 16'h0010);
    rd("ram10_kept", 16'h0010, 8'h11);
    run_dma("dma_odd", 1'b1, 514, 16'h4014);
    repeat (4) tick();
    chk("no_retrigger", cpu_rdy, 1'b1);

    // reset in the middle of a transfer
    wr(16'h4014, 8'h02);
    pulses = 0; guard = 0;
    while (pulses < 100 && guard < 1000) begin
      @(negedge clk);
      if (oam_we) pulses++;
      guard++;
      if (pulses < 100) tick();
    end
    chk("mid_reach_100", pulses, 100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_rdy", cpu_rdy, 1'b1);
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      @(negedge clk);
      if (oam_we) pulses++;
    end
    chk("post_reset_pulses", pulses, 0);
    tick();
    run_dma("dma_restart", m_par, m_par ? 514 : 513, 16'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
